tdc_wsign: RTL

Signed time-to-digital converter that sits directly downstream of the DTC-with-absolute-value stage. It measures, in clock cycles, the width of the DTC's output pulse and recombines it with the DTC's sign flag to rebuild a signed two's-complement code. The block closes the DTC→TDC loopback used to characterise the DTC on silicon and in simulation.

---
 rtl/tdc_pkg.sv | 20 ++
 rtl/tdc_sync2.sv | 21 ++
 rtl/tdc_wsign.sv | 97 +++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// Shared definitions for the signed TDC: FSM state encoding and the signed
// saturation limits for a WIDTH-bit two's-complement code.
package tdc_pkg;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int unsigned pos_limit(input int unsigned w);
    return (32'd1 << (w - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned neg_limit(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

endpackage

// File: rtl/tdc_sync2.sv
// Two-flop synchroniser for a single-bit level, async active-low reset to 0.
module tdc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tdc_wsign.sv
// Signed TDC: measures DTC pulse width in cycles and rebuilds a saturated signed code.
// Define TDC_SYNC_EN to pass pulse_in/sign_in through two-flop synchronisers first.
module tdc_wsign
  import tdc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pulse_in,
  input  logic                    sign_in,
  output logic signed [WIDTH-1:0] dout,
  output logic                    dout_valid,
  output logic                    overflow,
  output logic                    busy
);

  logic pulse_p0;
  logic sign_p0;
  logic ready;

`ifdef TDC_SYNC_EN
  logic [1:0] fill;

  tdc_sync2 u_sync_pulse (.clk(clk), .rst(rst), .d(pulse_in), .q(pulse_p0));
  tdc_sync2 u_sync_sign  (.clk(clk), .rst(rst), .d(sign_in),  .q(sign_p0));

  // Hold ARM until the synchronisers carry real samples, so a pulse in flight
  // at reset release is not mistaken for a fresh rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fill <= 2'b00;
    else      fill <= {fill[0], 1'b1};
  end
  assign ready = fill[1];
`else
  assign pulse_p0 = pulse_in;
  assign sign_p0  = sign_in;
  assign ready    = 1'b1;
`endif

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic             neg;

  // Returns {overflow, code}: magnitude clamped to the signed range, then negated if needed.
  function automatic logic [WIDTH:0] saturate(input logic [WIDTH-1:0] mag, input logic is_neg);
    logic [WIDTH-1:0] lim;
    logic [WIDTH-1:0] m;
    logic             ovf;
    lim = is_neg ? WIDTH'(neg_limit(WIDTH)) : WIDTH'(pos_limit(WIDTH));
    ovf = (mag > lim);
    m   = ovf ? lim : mag;
    return {ovf, (is_neg ? ({WIDTH{1'b0}} - m) : m)};
  endfunction

  // Measurement FSM on the (optionally synchronised) p0 inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARM;
      cnt        <= '0;
      neg        <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        ARM: begin
          if (ready && !pulse_p0) state <= IDLE;
        end
        IDLE, DONE: begin
          if (pulse_p0) begin
            state <= COUNT;
            cnt   <= WIDTH'(1);
            neg   <= sign_p0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        COUNT: begin
          if (pulse_p0) begin
            if (cnt != '1) cnt <= cnt + WIDTH'(1);
          end else begin
            state              <= DONE;
            {overflow, dout}   <= saturate(cnt, neg);
            dout_valid         <= 1'b1;
            busy               <= 1'b0;
          end
        end
        default: state <= ARM;
      endcase
    end
  end

endmodule
